answer_judge: RTL
=================

Name: answer_judge

Overview:
- Sits directly downstream of the player-input stage.
- Consumes the three latched answer digits and the 3-digit BCD question, computes digit1*digit2*digit3 with a sequential shift-add multiplier, and compares the product with the question.
- Reports GOOD/OUCH to the game-state controller, which uses it to move to the GOOD or OUCH state.

Parameters:
- INPUT_STATE, 4'b0100, STATE encoding in which judging may start.
- RES_GOOD, 2'b01, RESULT code when product equals question.
- RES_OUCH, 2'b10, RESULT code on mismatch or invalid input.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- STATE  input  4  current game state from controller.
- QUE_OK  input  1  high when a valid nonzero question is loaded.
- START  input  1  decide strobe (the same DEC button pulse that latches the answer digits).
- CLR  input  1  synchronous abort/clear.
- QUESTION  input  12  BCD question: [11:8] hundreds, [7:4] tens, [3:0] ones.
- DIG1, DIG2, DIG3  input  4 each  latched answer digits, expected 1..9.
- BUSY  output  1  high while a judgement is in progress.
- DONE  output  1  one-cycle pulse when RESULT is updated.
- RESULT  output  2  2'b00 none, RES_GOOD, or RES_OUCH; held until cleared.

Behaviour:
- Reset (RST=0, async): state IDLE; BUSY=0, DONE=0, RESULT=2'b00; all internal registers 0.
- Start acceptance:
  - START is accepted only in IDLE with STATE==INPUT_STATE and QUE_OK=1; otherwise it is ignored.
  - START while BUSY is ignored; it does not restart the judgement.
  - On the accepting edge, QUESTION and DIG1..3 are captured, RESULT is cleared to 00, BUSY=1, and the FSM enters CONV.
  - Inputs are not re-sampled during the run.
- FSM: IDLE -> CONV -> MULA -> MULB -> CMP -> IDLE.
  - CONV (1 cycle): Qbin = H*100 + T*10 + O, 10 bits, built from shifts and adds. A flag records an invalid capture: any BCD digit >9, any DIG = 0, or any DIG >9.
  - MULA (4 cycles): shift-add of DIG1*DIG2, one multiplier bit per cycle, LSB first; 7-bit partial product.
  - MULB (4 cycles): shift-add of the MULA product times DIG3; 10-bit product (max 729, no overflow).
  - CMP (1 cycle): RESULT = RES_GOOD if the invalid flag is 0 and product==Qbin, else RES_OUCH. DONE=1 for exactly this following cycle; BUSY=0; return to IDLE.
- Latency: START accepted at edge N gives RESULT valid and DONE high after edge N+10. Latency is fixed, independent of operand values.
- RESULT hold and clear:
  - RESULT holds after DONE until the next accepted START, CLR, or reset.
  - STATE changes alone do not clear RESULT.
- CLR: at any state, the next edge forces IDLE, BUSY=0, DONE=0, RESULT=00. CLR has priority over START in the same cycle.
- Mid-run STATE change: if STATE leaves INPUT_STATE during a run, the run completes normally. The controller is responsible for ignoring a stale DONE.
- Reset mid-run: immediate return to the reset values; no DONE is produced.
- Question 000 never reaches a run, because QUE_OK=0 gates START.

Test Plan:
- Valid match: QUESTION=12'h105, DIG=3,5,7, START in state 0100 with QUE_OK=1 -> BUSY for 10 cycles, DONE pulse after edge N+10, RESULT=01.
- Mismatch and maximum operands:
  - QUESTION=12'h105, DIG=3,5,8 -> RESULT=10 at the same latency.
  - QUESTION=12'h729, DIG=9,9,9 -> RESULT=01 (max-width check).
- Invalid inputs:
  - DIG2=0 with QUESTION=12'h000-independent values -> RESULT=10.
  - QUESTION=12'h1A5 -> RESULT=10.
- Start gating:
  - START pulsed again 3 cycles into a run -> ignored; DONE still at N+10, and only once.
  - START with STATE=4'b0011 or QUE_OK=0 -> no BUSY, RESULT unchanged.
- Abort and reset:
  - CLR asserted in MULB -> next cycle IDLE, RESULT=00, no DONE.
  - RST low asynchronously mid-MULA -> outputs 0 immediately.
  - A new START after release -> correct result.

Source files
------------

// File: rtl/answer_judge.sv
// Judges a player's three-digit answer: multiplies DIG1*DIG2*DIG3 with a
// sequential shift-add multiplier and compares the product with the BCD question.
module answer_judge #(
  parameter logic [3:0] INPUT_STATE = 4'b0100,
  parameter logic [1:0] RES_GOOD    = 2'b01,
  parameter logic [1:0] RES_OUCH    = 2'b10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  STATE,
  input  logic        QUE_OK,
  input  logic        START,
  input  logic        CLR,
  input  logic [11:0] QUESTION,
  input  logic [3:0]  DIG1,
  input  logic [3:0]  DIG2,
  input  logic [3:0]  DIG3,
  output logic        BUSY,
  output logic        DONE,
  output logic [1:0]  RESULT
);

  typedef enum logic [2:0] {IDLE, CONV, MULA, MULB, CMP} state_t;

  state_t      state;
  logic [11:0] que_reg;
  logic [3:0]  dig1_r;
  logic [3:0]  dig2_r;
  logic [3:0]  dig3_r;
  logic [9:0]  q_bin;
  logic        bad;
  logic [6:0]  prod_a;
  logic [9:0]  prod;
  logic [1:0]  bit_cnt;

  logic [9:0]  hun;
  logic [9:0]  ten;
  logic [9:0]  one;
  logic [9:0]  q_bin_next;
  logic        bad_next;
  logic [6:0]  add_a;
  logic [9:0]  add_b;

  assign hun = {6'b0, que_reg[11:8]};
  assign ten = {6'b0, que_reg[7:4]};
  assign one = {6'b0, que_reg[3:0]};

  // H*100 = H*64 + H*32 + H*4, T*10 = T*8 + T*2
  assign q_bin_next = (hun << 6) + (hun << 5) + (hun << 2) + (ten << 3) + (ten << 1) + one;

  assign bad_next = (que_reg[11:8] > 4'd9) || (que_reg[7:4] > 4'd9) || (que_reg[3:0] > 4'd9) ||
                    (dig1_r == 4'd0) || (dig1_r > 4'd9) ||
                    (dig2_r == 4'd0) || (dig2_r > 4'd9) ||
                    (dig3_r == 4'd0) || (dig3_r > 4'd9);

  assign add_a = dig2_r[bit_cnt] ? ({3'b0, dig1_r} << bit_cnt) : 7'd0;
  assign add_b = dig3_r[bit_cnt] ? ({3'b0, prod_a} << bit_cnt) : 10'd0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      que_reg <= 12'd0;
      dig1_r  <= 4'd0;
      dig2_r  <= 4'd0;
      dig3_r  <= 4'd0;
      q_bin   <= 10'd0;
      bad     <= 1'b0;
      prod_a  <= 7'd0;
      prod    <= 10'd0;
      bit_cnt <= 2'd0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= 2'b00;
    end else if (CLR) begin
      state   <= IDLE;
      bit_cnt <= 2'd0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= 2'b00;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START && (STATE == INPUT_STATE) && QUE_OK) begin
            que_reg <= QUESTION;
            dig1_r  <= DIG1;
            dig2_r  <= DIG2;
            dig3_r  <= DIG3;
            prod_a  <= 7'd0;
            prod    <= 10'd0;
            bit_cnt <= 2'd0;
            RESULT  <= 2'b00;
            BUSY    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          q_bin <= q_bin_next;
          bad   <= bad_next;
          state <= MULA;
        end
        // bit_cnt wraps from 3 back to 0, so MULB starts at multiplier bit 0
        MULA: begin
          prod_a  <= prod_a + add_a;
          bit_cnt <= bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) state <= MULB;
        end
        MULB: begin
          prod    <= prod + add_b;
          bit_cnt <= bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) state <= CMP;
        end
        CMP: begin
          RESULT <= (!bad && (prod == q_bin)) ? RES_GOOD : RES_OUCH;
          DONE   <= 1'b1;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
